// File: rtl/dla_pkg.sv
// Shared DLA link definitions, common to the transmit and receive blocks.
package dla_pkg;
  localparam int DLA_DATA_W  = 32;
  localparam int DLA_WAKE_TO = 15;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WAKE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } dla_tx_state_t;
endpackage

// File: rtl/dla_link_tx_if.sv
// Source-side and link-side signals of the DLA transmitter.
interface dla_link_tx_if #(parameter int DW = dla_pkg::DLA_DATA_W);
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready;
  logic          is_allocatable_in;
  logic          is_on_off_in;
  logic [DW-1:0] data_out;
  logic          is_valid_out;
  logic          is_on_off_out;
  logic          is_allocatable_out;

  modport master (
    input  src_valid, src_data, is_allocatable_in, is_on_off_in,
    output src_ready, data_out, is_valid_out, is_on_off_out, is_allocatable_out
  );
  modport slave (
    output src_valid, src_data, is_allocatable_in, is_on_off_in,
    input  src_ready, data_out, is_valid_out, is_on_off_out, is_allocatable_out
  );
endinterface

// File: rtl/dla_sync_fifo.sv
// Single-clock staging FIFO; occupancy counter separates full from empty.
module dla_sync_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr, r_rd;
  logic [CW-1:0]     r_cnt;
  logic              w_push, w_pop;

  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign dout   = r_mem[r_rd];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/dla_link_tx.sv
// DLA link transmitter: lane power FSM, staging FIFO and registered link output.
module dla_link_tx #(
  parameter int DLA_DATA_W = dla_pkg::DLA_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int WAKE_TO    = dla_pkg::DLA_WAKE_TO
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  dla_link_tx_if.master  bus,
  output logic           wake_err,
  output logic [15:0]    tx_count
);
  import dla_pkg::*;

  localparam int WCW = $clog2(WAKE_TO + 1);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  dla_tx_state_t         r_state, w_nxt;
  logic [WCW-1:0]        r_wcnt;
  logic                  r_wake_err, w_timeout;
  logic                  r_vld;
  logic [DLA_DATA_W-1:0] r_data;
  logic [15:0]           r_txc;
  logic                  w_full, w_empty, w_push, w_pop, w_ld, w_xfer, w_flush;
  logic [DLA_DATA_W-1:0] w_head;
  logic [CW-1:0]         w_cnt;

  // Remote power loss while draining: staged beats cannot be delivered.
  assign w_flush = (r_state == ST_DRAIN) & ~bus.is_on_off_in;
  assign w_xfer  = r_vld & bus.is_allocatable_in & ~w_flush;
  assign w_ld    = (~r_vld | w_xfer) & ~w_flush;
  assign w_pop   = w_ld & ~w_empty;
  assign w_push  = bus.src_valid & bus.src_ready;

  dla_sync_fifo #(.DATA_W(DLA_DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (bus.src_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_cnt)
  );

  always_comb begin
    w_nxt     = r_state;
    w_timeout = 1'b0;
    case (r_state)
      ST_OFF:    if (en) w_nxt = ST_WAKE;
      ST_WAKE: begin
        if (bus.is_on_off_in)   w_nxt = ST_ACTIVE;
        else if (!en)           w_nxt = ST_OFF;
        else if (r_wcnt == WCW'(WAKE_TO)) begin
          w_nxt     = ST_OFF;
          w_timeout = 1'b1;
        end
      end
      ST_ACTIVE: if (!en || !bus.is_on_off_in) w_nxt = ST_DRAIN;
      ST_DRAIN:  if (w_flush || (w_empty && !r_vld)) w_nxt = ST_OFF;
      default:   w_nxt = ST_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_OFF;
      r_wcnt     <= '0;
      r_wake_err <= 1'b0;
      r_vld      <= 1'b0;
      r_data     <= '0;
      r_txc      <= '0;
    end else begin
      r_state    <= w_nxt;
      r_wake_err <= w_timeout;
      // Held at zero outside WAKE, so it starts from zero on every entry.
      r_wcnt     <= (r_state == ST_WAKE) ? r_wcnt + 1'b1 : '0;
      if (w_flush)   r_vld <= 1'b0;
      else if (w_ld) r_vld <= ~w_empty;
      if (w_pop)  r_data <= w_head;
      if (w_xfer) r_txc  <= r_txc + 1'b1;
    end
  end

  assign bus.src_ready          = ~w_full & (r_state == ST_ACTIVE);
  assign bus.data_out           = r_data;
  assign bus.is_valid_out       = r_vld;
  assign bus.is_on_off_out      = (r_state != ST_OFF);
  assign bus.is_allocatable_out = (r_state == ST_ACTIVE) & (w_cnt == '0) & ~r_vld;
  assign wake_err               = r_wake_err;
  assign tx_count               = r_txc;
endmodule

// File: tb/tb_dla_link_tx.sv
// Directed bench for dla_link_tx: bring-up, timeout, back-pressure, drain, remote drop, reset.
module tb_dla_link_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        wake_err;
  logic [15:0] tx_count;
  int          n_run = 0, n_fail = 0;
  int          rx_n = 0, n_werr = 0;
  logic [31:0] rx_mem [64];

  dla_link_tx_if #(.DW(32)) bus ();

  dla_link_tx #(.DLA_DATA_W(32), .FIFO_DEPTH(4), .WAKE_TO(15)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .bus      (bus),
    .wake_err (wake_err),
    .tx_count (tx_count)
  );

  always #5 clk = ~clk;

  // Remote-side receiver log and wake error pulse counter.
  always @(posedge clk) begin
    if (rst_n && bus.is_valid_out && bus.is_allocatable_in) begin
      rx_mem[rx_n % 64] <= bus.data_out;
      rx_n <= rx_n + 1;
    end
    if (rst_n && wake_err) n_werr <= n_werr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    en = 1'b0;
    bus.src_valid = 1'b0;
    bus.src_data = '0;
    bus.is_allocatable_in = 1'b0;
    bus.is_on_off_in = 1'b0;
    tick(2);
    chk("rst_valid", {31'd0, bus.is_valid_out}, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_onoff", {31'd0, bus.is_on_off_out}, 0);
    chk("rst_alloc", {31'd0, bus.is_allocatable_out}, 0);
    chk("rst_ready", {31'd0, bus.src_ready}, 0);
    chk("rst_txc", {16'd0, tx_count}, 0);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic bring_up;
    en = 1'b1;
    bus.is_on_off_in = 1'b1;
    tick(2);
    chk("up_alloc", {31'd0, bus.is_allocatable_out}, 1);
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    int   k;
    logic acc;
    k = 0;
    for (int c = 0; c < 50 && k < n; c++) begin
      bus.src_valid = 1'b1;
      bus.src_data = base + k;
      acc = bus.src_ready;
      tick(1);
      if (acc) k++;
    end
    bus.src_valid = 1'b0;
    chk("push_cnt", k, n);
  endtask

  initial begin
    int   r0, w0, i;
    logic acc;

    // Bring-up with a delayed remote power-on
    do_reset();
    w0 = n_werr;
    en = 1'b1;
    tick(1);
    chk("up_onoff_first", {31'd0, bus.is_on_off_out}, 1);
    chk("up_alloc_wake", {31'd0, bus.is_allocatable_out}, 0);
    tick(2);
    bus.is_on_off_in = 1'b1;
    tick(1);
    chk("up_alloc", {31'd0, bus.is_allocatable_out}, 1);
    chk("up_onoff", {31'd0, bus.is_on_off_out}, 1);
    chk("up_ready", {31'd0, bus.src_ready}, 1);
    chk("up_werr", n_werr - w0, 0);

    // Wake timeout: 16 WAKE cycles (counter 0..15), then OFF with a pulse
    do_reset();
    w0 = n_werr;
    en = 1'b1;
    tick(16);
    chk("to_onoff_wake", {31'd0, bus.is_on_off_out}, 1);
    chk("to_werr_early", {31'd0, wake_err}, 0);
    tick(1);
    chk("to_werr", {31'd0, wake_err}, 1);
    chk("to_onoff_off", {31'd0, bus.is_on_off_out}, 0);
    en = 1'b0;
    tick(1);
    chk("to_werr_clr", {31'd0, wake_err}, 0);
    chk("to_onoff_stay", {31'd0, bus.is_on_off_out}, 0);
    tick(1);
    chk("to_werr_once", n_werr - w0, 1);

    // Back-pressure: 5 stall cycles then the remote opens
    do_reset();
    bring_up();
    r0 = rx_n;
    i = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 2 || c == 4) chk("bp_hold", bus.data_out, 32'hA0);
      if (c == 5) begin
        chk("bp_accepted", i, 5);
        chk("bp_ready_low", {31'd0, bus.src_ready}, 0);
        chk("bp_hold5", bus.data_out, 32'hA0);
        chk("bp_valid", {31'd0, bus.is_valid_out}, 1);
        chk("bp_alloc_out", {31'd0, bus.is_allocatable_out}, 0);
        bus.is_allocatable_in = 1'b1;
      end
      bus.src_valid = (i < 6);
      bus.src_data = 32'hA0 + i;
      acc = bus.src_valid & bus.src_ready;
      tick(1);
      if (acc) i++;
    end
    bus.src_valid = 1'b0;
    chk("bp_rxn", rx_n - r0, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("bp_rx%0d", k), rx_mem[(r0 + k) % 64], 32'hA0 + k);
    chk("bp_txc", {16'd0, tx_count}, 6);
    chk("bp_idle", {31'd0, bus.is_allocatable_out}, 1);

    // Drain: three staged beats delivered after en drops
    do_reset();
    bring_up();
    r0 = rx_n;
    push_n(3, 32'hB0);
    en = 1'b0;
    tick(1);
    chk("dr_ready", {31'd0, bus.src_ready}, 0);
    chk("dr_onoff", {31'd0, bus.is_on_off_out}, 1);
    chk("dr_valid", {31'd0, bus.is_valid_out}, 1);
    bus.is_allocatable_in = 1'b1;
    for (int c = 0; c < 20 && bus.is_on_off_out; c++) tick(1);
    chk("dr_off", {31'd0, bus.is_on_off_out}, 0);
    chk("dr_txc", {16'd0, tx_count}, 3);
    chk("dr_rxn", rx_n - r0, 3);
    for (int k = 0; k < 3; k++) chk($sformatf("dr_rx%0d", k), rx_mem[(r0 + k) % 64], 32'hB0 + k);

    // Remote drop during DRAIN flushes the staged beats
    do_reset();
    bring_up();
    r0 = rx_n;
    push_n(3, 32'hC0);
    en = 1'b0;
    tick(1);
    chk("rd_onoff_drain", {31'd0, bus.is_on_off_out}, 1);
    chk("rd_valid_pre", {31'd0, bus.is_valid_out}, 1);
    bus.is_on_off_in = 1'b0;
    tick(1);
    chk("rd_onoff", {31'd0, bus.is_on_off_out}, 0);
    chk("rd_valid", {31'd0, bus.is_valid_out}, 0);
    chk("rd_txc", {16'd0, tx_count}, 0);
    bus.is_allocatable_in = 1'b1;
    tick(3);
    chk("rd_valid_late", {31'd0, bus.is_valid_out}, 0);
    chk("rd_rxn", rx_n - r0, 0);

    // Reset in the middle of a burst
    do_reset();
    bring_up();
    r0 = rx_n;
    bus.is_allocatable_in = 1'b1;
    push_n(4, 32'hD0);
    bus.is_allocatable_in = 1'b0;
    chk("mr_valid", {31'd0, bus.is_valid_out}, 1);
    chk("mr_data", bus.data_out, 32'hD2);
    chk("mr_txc_pre", {16'd0, tx_count}, 2);
    rst_n = 1'b0;
    #1;
    chk("mr_valid_rst", {31'd0, bus.is_valid_out}, 0);
    chk("mr_data_rst", bus.data_out, 0);
    chk("mr_onoff_rst", {31'd0, bus.is_on_off_out}, 0);
    chk("mr_txc_rst", {16'd0, tx_count}, 0);
    en = 1'b0;
    bus.is_on_off_in = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    bring_up();
    chk("mr_valid_post", {31'd0, bus.is_valid_out}, 0);
    chk("mr_rxn", rx_n - r0, 2);
    chk("mr_txc_post", {16'd0, tx_count}, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
